maze_map_scanner: RTL and testbench



---
 rtl/maze_map_scanner_if.sv | 24 ++
 rtl/maze_map_scanner.sv | 184 ++++++++++++++++++
 tb/tb_maze_map_scanner.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_map_scanner_if.sv
// Synchronous-read port between the maze map RAM and its scanner.
// The scanner is the master: it drives the strobe and address, the RAM returns data one cycle later.
interface maze_map_scanner_if #(
  parameter int CELL_W = 7,
  parameter int IDX_W  = 7
);

  logic              rd_en;
  logic [IDX_W-1:0]  rd_addr;
  logic [CELL_W-1:0] rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/maze_map_scanner.sv
// Walks the whole maze map once per go pulse, locating start/goal cells and counting walls and marks.
// The path-planning controller waits for the one-cycle done pulse before trusting the results.
module maze_map_scanner #(
  parameter int              CELL_W     = 7,
  parameter int              IDX_W      = 7,
  parameter int              NUM_CELLS  = 100,
  parameter logic [CELL_W-1:0] START_CODE = 7'h3F,
  parameter logic [CELL_W-1:0] GOAL_CODE  = 7'h00,
  parameter int              WALL_BIT   = 6,
  parameter int              MARK_HI    = 5,
  parameter logic [1:0]      MARK_VAL   = 2'b10
) (
  input  logic                  m_clock,
  input  logic                  p_reset,
  input  logic                  go,
  input  logic                  abort,
  maze_map_scanner_if.master    map,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      start_idx,
  output logic [IDX_W-1:0]      goal_idx,
  output logic                  start_found,
  output logic                  goal_found,
  output logic                  dup_err,
  output logic [IDX_W:0]        wall_cnt,
  output logic [IDX_W:0]        mark_cnt,
  output logic [CELL_W-1:0]     data_out
);

  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(NUM_CELLS - 1);
  localparam logic [IDX_W-1:0] ADDR_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [IDX_W-1:0] addr;
  logic             vld;
  logic [IDX_W-1:0] vld_addr;
  logic             go_accept;
  logic             abort_hit;
  logic             is_goal;
  logic             is_start;
  logic             is_wall;
  logic             is_mark;

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    map.rd_en  = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          next_state = SCAN;
        end
      end
      SCAN: begin
        busy      = 1'b1;
        map.rd_en = 1'b1;
        if (abort) begin
          next_state = IDLE;
        end else if (addr == LAST_ADDR) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        busy       = 1'b1;
        next_state = abort ? IDLE : DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign go_accept   = (state == IDLE) && go;
  assign abort_hit   = busy && abort;
  assign map.rd_addr = addr;

  // The address parks on the last cell after the scan so the RAM port stays quiet and predictable.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      addr <= '0;
    end else if (go_accept) begin
      addr <= '0;
    end else if ((state == SCAN) && (addr != LAST_ADDR)) begin
      addr <= addr + ADDR_ONE;
    end
  end

  // rd_data lags the strobe by one cycle, so the index travels with a matching valid flag.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      vld      <= 1'b0;
      vld_addr <= '0;
    end else begin
      vld      <= map.rd_en && !abort;
      vld_addr <= addr;
    end
  end

  always_comb begin
    is_goal  = 1'b0;
    is_start = 1'b0;
    is_wall  = 1'b0;
    is_mark  = 1'b0;
    if (map.rd_data == GOAL_CODE) begin
      is_goal = 1'b1;
    end else if (map.rd_data == START_CODE) begin
      is_start = 1'b1;
    end else if (map.rd_data[WALL_BIT]) begin
      is_wall = 1'b1;
    end else if (map.rd_data[MARK_HI -: 2] == MARK_VAL) begin
      is_mark = 1'b1;
    end
  end

  // First occurrence keeps its index, so duplicates resolve to the lowest cell.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      start_idx   <= '0;
      goal_idx    <= '0;
      start_found <= 1'b0;
      goal_found  <= 1'b0;
      dup_err     <= 1'b0;
      wall_cnt    <= '0;
      mark_cnt    <= '0;
      data_out    <= '0;
    end else if (go_accept) begin
      start_idx   <= '0;
      goal_idx    <= '0;
      start_found <= 1'b0;
      goal_found  <= 1'b0;
      dup_err     <= 1'b0;
      wall_cnt    <= '0;
      mark_cnt    <= '0;
      data_out    <= '0;
    end else if (abort_hit) begin
      start_found <= 1'b0;
      goal_found  <= 1'b0;
      dup_err     <= 1'b0;
    end else if (vld) begin
      data_out <= map.rd_data;
      if (is_goal) begin
        if (!goal_found) begin
          goal_idx   <= vld_addr;
          goal_found <= 1'b1;
        end else begin
          dup_err <= 1'b1;
        end
      end else if (is_start) begin
        if (!start_found) begin
          start_idx   <= vld_addr;
          start_found <= 1'b1;
        end else begin
          dup_err <= 1'b1;
        end
      end else if (is_wall) begin
        wall_cnt <= wall_cnt + CNT_ONE;
      end else if (is_mark) begin
        mark_cnt <= mark_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_maze_map_scanner.sv
// Directed bench for maze_map_scanner: expected scan results are queued at go and
// compared by an independent monitor whenever done pulses.
module tb_maze_map_scanner;

  localparam int CELL_W    = 7;
  localparam int IDX_W     = 7;
  localparam int NUM_CELLS = 100;

  logic              m_clock = 1'b0;
  logic              p_reset;
  logic              go;
  logic              abort;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  start_idx;
  logic [IDX_W-1:0]  goal_idx;
  logic              start_found;
  logic              goal_found;
  logic              dup_err;
  logic [IDX_W:0]    wall_cnt;
  logic [IDX_W:0]    mark_cnt;
  logic [CELL_W-1:0] data_out;

  maze_map_scanner_if #(.CELL_W(CELL_W), .IDX_W(IDX_W)) bus ();

  maze_map_scanner #(
    .CELL_W(CELL_W), .IDX_W(IDX_W), .NUM_CELLS(NUM_CELLS)
  ) dut (
    .m_clock(m_clock), .p_reset(p_reset), .go(go), .abort(abort), .map(bus),
    .busy(busy), .done(done), .start_idx(start_idx), .goal_idx(goal_idx),
    .start_found(start_found), .goal_found(goal_found), .dup_err(dup_err),
    .wall_cnt(wall_cnt), .mark_cnt(mark_cnt), .data_out(data_out)
  );

  always #5 m_clock = ~m_clock;

  logic [CELL_W-1:0] mem [0:127];

  initial bus.rd_data = '0;
  always @(posedge m_clock) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  typedef struct {
    int start_idx;
    int goal_idx;
    int start_found;
    int goal_found;
    int dup_err;
    int wall_cnt;
    int mark_cnt;
    int data_out;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge m_clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("start_idx",   32'(start_idx),   32'(e.start_idx));
        checkOutput("goal_idx",    32'(goal_idx),    32'(e.goal_idx));
        checkOutput("start_found", 32'(start_found), 32'(e.start_found));
        checkOutput("goal_found",  32'(goal_found),  32'(e.goal_found));
        checkOutput("dup_err",     32'(dup_err),     32'(e.dup_err));
        checkOutput("wall_cnt",    32'(wall_cnt),    32'(e.wall_cnt));
        checkOutput("mark_cnt",    32'(mark_cnt),    32'(e.mark_cnt));
        checkOutput("data_out",    32'(data_out),    32'(e.data_out));
      end
    end
  end

  task automatic fillMap(input logic [CELL_W-1:0] val);
    for (int i = 0; i < 128; i++) mem[i] = val;
  endtask

  task automatic loadWallMarkMap();
    fillMap(7'h01);
    for (int i = 10; i < 20; i++) mem[i] = 7'h40;
    for (int i = 20; i < 25; i++) mem[i] = 7'h20;
    mem[25] = 7'h7F;
    mem[3]  = 7'h3F;
    mem[99] = 7'h00;
  endtask

  // Full scan: queue expectation, pulse go (optionally with abort), check address stream and done latency.
  task automatic applyStimulus(input exp_t e, input bit with_abort);
    int lat;
    exp_q.push_back(e);
    @(posedge m_clock); #1;
    go = 1'b1;
    abort = with_abort;
    @(posedge m_clock); #1;
    go = 1'b0;
    abort = 1'b0;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge m_clock);
      if (k <= NUM_CELLS) begin
        if (bus.rd_en !== 1'b1 || bus.rd_addr !== IDX_W'(k - 1)) begin
          checkOutput("rd_addr_seq", 32'(bus.rd_addr), 32'(k - 1));
        end
      end
      if (k == NUM_CELLS + 1) begin
        checkOutput("drain_rd_en", 32'(bus.rd_en), 32'd0);
        checkOutput("drain_busy",  32'(busy),      32'd1);
      end
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    checkOutput("done_latency", 32'(lat), 32'(NUM_CELLS + 2));
    @(negedge m_clock);
    checkOutput("done_width",   32'(done),     32'd0);
    checkOutput("hold_goal",    32'(goal_idx), 32'(e.goal_idx));
    checkOutput("hold_wall",    32'(wall_cnt), 32'(e.wall_cnt));
    checkOutput("idle_busy",    32'(busy),     32'd0);
  endtask

  exp_t e;

  initial begin
    p_reset = 1'b1;
    go      = 1'b0;
    abort   = 1'b0;
    fillMap(7'h01);
    repeat (3) @(posedge m_clock);
    @(negedge m_clock);
    checkOutput("rst_busy",     32'(busy),        32'd0);
    checkOutput("rst_done",     32'(done),        32'd0);
    checkOutput("rst_rd_en",    32'(bus.rd_en),   32'd0);
    checkOutput("rst_rd_addr",  32'(bus.rd_addr), 32'd0);
    checkOutput("rst_found",    32'({start_found, goal_found, dup_err}), 32'd0);
    checkOutput("rst_counts",   32'({wall_cnt, mark_cnt}), 32'd0);
    checkOutput("rst_data_out", 32'(data_out),    32'd0);
    p_reset = 1'b0;

    $display("[TB] scan 1: start 0, goal 55");
    fillMap(7'h01);
    mem[0]  = 7'h3F;
    mem[55] = 7'h00;
    e = '{start_idx:0, goal_idx:55, start_found:1, goal_found:1, dup_err:0,
          wall_cnt:0, mark_cnt:0, data_out:'h01};
    applyStimulus(e, 1'b0);

    $display("[TB] scan 2: walls and marks, goal on last cell");
    loadWallMarkMap();
    e = '{start_idx:3, goal_idx:99, start_found:1, goal_found:1, dup_err:0,
          wall_cnt:11, mark_cnt:5, data_out:'h00};
    applyStimulus(e, 1'b0);

    $display("[TB] scan 3: duplicate start, go together with abort");
    fillMap(7'h01);
    mem[7]  = 7'h3F;
    mem[40] = 7'h3F;
    mem[8]  = 7'h00;
    e = '{start_idx:7, goal_idx:8, start_found:1, goal_found:1, dup_err:1,
          wall_cnt:0, mark_cnt:0, data_out:'h01};
    applyStimulus(e, 1'b1);

    $display("[TB] scan 4: no goal");
    fillMap(7'h01);
    mem[50] = 7'h3F;
    e = '{start_idx:50, goal_idx:0, start_found:1, goal_found:0, dup_err:0,
          wall_cnt:0, mark_cnt:0, data_out:'h01};
    applyStimulus(e, 1'b0);

    $display("[TB] scan 5: abort at T+30 then rescan");
    loadWallMarkMap();
    @(posedge m_clock); #1;
    go = 1'b1;
    @(posedge m_clock); #1;
    go = 1'b0;
    repeat (19) @(posedge m_clock);
    #1;
    checkOutput("pre_abort_start", 32'(start_found), 32'd1);
    repeat (10) @(posedge m_clock);
    #1;
    abort = 1'b1;
    @(posedge m_clock); #1;
    abort = 1'b0;
    checkOutput("abort_busy",  32'(busy),  32'd0);
    checkOutput("abort_rd_en", 32'(bus.rd_en), 32'd0);
    checkOutput("abort_found", 32'({start_found, goal_found, dup_err}), 32'd0);
    repeat (8) @(posedge m_clock);
    e = '{start_idx:3, goal_idx:99, start_found:1, goal_found:1, dup_err:0,
          wall_cnt:11, mark_cnt:5, data_out:'h00};
    applyStimulus(e, 1'b0);

    $display("[TB] scan 6: go during scan ignored, then reset mid-scan");
    loadWallMarkMap();
    @(posedge m_clock); #1;
    go = 1'b1;
    @(posedge m_clock); #1;
    go = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      go = (k == 5);
      @(negedge m_clock);
      checkOutput("rescan_addr", 32'(bus.rd_addr), 32'(k - 1));
      @(posedge m_clock); #1;
    end
    go = 1'b0;
    @(negedge m_clock);
    checkOutput("pre_reset_wall", 32'(wall_cnt), 32'd8);
    #2;
    p_reset = 1'b1;
    #1;
    checkOutput("arst_busy",     32'(busy),        32'd0);
    checkOutput("arst_rd_en",    32'(bus.rd_en),   32'd0);
    checkOutput("arst_rd_addr",  32'(bus.rd_addr), 32'd0);
    checkOutput("arst_found",    32'({start_found, goal_found, dup_err}), 32'd0);
    checkOutput("arst_start",    32'(start_idx),   32'd0);
    checkOutput("arst_counts",   32'({wall_cnt, mark_cnt}), 32'd0);
    checkOutput("arst_data_out", 32'(data_out),    32'd0);
    repeat (2) @(negedge m_clock);
    p_reset = 1'b0;
    repeat (120) @(negedge m_clock);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

    checkOutput("pending_results", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
